// File: rtl/mole_datapath.sv
// Whack-a-mole game datapath: game tick and time keeping, mole LED drive, hit/miss
// scoring, and the control/timer handshake signals that feed back into the game FSM.
module mole_datapath #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int GAME_TICKS = 600,
  parameter int MOLE_TICKS = 10,
  parameter int GAP_TICKS  = 3,
  parameter int SCORE_W    = 8,
  localparam int TIME_W  = $clog2(GAME_TICKS + 1),
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int CNT_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  input  logic [3:0]         keys,
  output logic               control_signal,
  output logic               timer_signal,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [TIME_W-1:0]  time_left,
  output logic [3:0]         mole_led,
  output logic [1:0]         phase_dbg
);

  // Handshake: control_signal is a one-cycle request; the FSM acknowledges it by
  // changing state, and no further request is raised until that change is seen.
  typedef enum logic [1:0] {PH_IDLE, PH_GAP, PH_UP, PH_ACK} phase_e;

  localparam logic [3:0]         ST_START  = 4'd0;
  localparam logic [3:0]         ST_GAME   = 4'd1;
  localparam logic [3:0]         ST_OVER   = 4'd6;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]   MOLE_LAST = CNT_W'(MOLE_TICKS - 1);
  localparam logic [TIME_W-1:0]  GAME_TIME = TIME_W'(GAME_TICKS);
  localparam logic [SCORE_W-1:0] SAT       = '1;
  localparam int                 SUM_W     = SCORE_W + 1;

  phase_e              phase_q, phase_d, dispatch;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]    mole_cnt_q, mole_cnt_d;
  logic [3:0]          lat_state_q, lat_state_d;
  logic [3:0]          keys_q, keys_d;
  logic                control_signal_q, control_signal_d;
  logic                timer_signal_q, timer_signal_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  misses_q, misses_d;
  logic [TIME_W-1:0]   time_left_q, time_left_d;
  logic [3:0]          mole_led_q, mole_led_d;

  logic                is_start, is_play, is_mole, tick, leave;
  logic [3:0]          rise, mole_bit;
  logic [1:0]          miss_inc;
  logic [SUM_W-1:0]    miss_sum;

  always_comb begin
    mole_bit = 4'b0000;
    case (state)
      4'd2:    mole_bit = 4'b0001;
      4'd3:    mole_bit = 4'b0010;
      4'd4:    mole_bit = 4'b0100;
      4'd5:    mole_bit = 4'b1000;
      default: mole_bit = 4'b0000;
    endcase
    is_start = (state == ST_START) || (state > ST_OVER);
    is_mole  = |mole_bit;
    is_play  = is_mole || (state == ST_GAME);
    rise     = keys & ~keys_q;
    tick     = is_play && (tick_cnt_q == TICK_LAST);
    if (state == ST_GAME)  dispatch = PH_GAP;
    else if (is_mole)      dispatch = PH_UP;
    else                   dispatch = PH_IDLE;

    keys_d           = keys;
    tick_cnt_d       = (is_play && !tick) ? tick_cnt_q + 1'b1 : '0;
    phase_d          = phase_q;
    gap_cnt_d        = gap_cnt_q;
    mole_cnt_d       = mole_cnt_q;
    lat_state_d      = lat_state_q;
    control_signal_d = 1'b0;
    score_d          = score_q;
    misses_d         = misses_q;
    time_left_d      = time_left_q;
    miss_inc         = 2'd0;
    leave            = 1'b0;

    if (is_start) begin
      time_left_d = GAME_TIME;
      score_d     = '0;
      misses_d    = '0;
    end else if (tick && (time_left_q != '0)) begin
      time_left_d = time_left_q - 1'b1;
    end
    timer_signal_d = (time_left_d == '0) && !is_start;

    case (phase_q)
      PH_IDLE: leave = 1'b1;
      PH_GAP: begin
        if (state != ST_GAME) begin
          leave = 1'b1;
        end else if (tick) begin
          // Once the gap has elapsed it is held; the request is withheld while time is out.
          if (gap_cnt_q >= GAP_LAST) begin
            if (!timer_signal_q) begin
              control_signal_d = 1'b1;
              phase_d          = PH_ACK;
              lat_state_d      = state;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      PH_UP: begin
        if (!is_mole) begin
          leave = 1'b1;
        end else if (|(rise & mole_bit)) begin
          score_d          = (score_q == SAT) ? SAT : score_q + 1'b1;
          control_signal_d = 1'b1;
          phase_d          = PH_ACK;
          lat_state_d      = state;
        end else begin
          if (|(rise & ~mole_bit)) miss_inc = miss_inc + 2'd1;
          if (tick) begin
            if (mole_cnt_q >= MOLE_LAST) begin
              miss_inc         = miss_inc + 2'd1;
              control_signal_d = 1'b1;
              phase_d          = PH_ACK;
              lat_state_d      = state;
            end else begin
              mole_cnt_d = mole_cnt_q + 1'b1;
            end
          end
        end
      end
      PH_ACK: if (state != lat_state_q) leave = 1'b1;
      default: leave = 1'b1;
    endcase

    if (leave) begin
      phase_d    = dispatch;
      gap_cnt_d  = '0;
      mole_cnt_d = '0;
    end

    // A wrong press and an expiry in the same cycle both count, saturating at SAT.
    miss_sum = {1'b0, misses_q} + SUM_W'(miss_inc);
    if (miss_inc != 2'd0) misses_d = miss_sum[SCORE_W] ? SAT : miss_sum[SCORE_W-1:0];

    mole_led_d = (phase_d == PH_UP) ? mole_bit : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q          <= PH_IDLE;
      tick_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      mole_cnt_q       <= '0;
      lat_state_q      <= '0;
      keys_q           <= '0;
      control_signal_q <= 1'b0;
      timer_signal_q   <= 1'b0;
      score_q          <= '0;
      misses_q         <= '0;
      time_left_q      <= GAME_TIME;
      mole_led_q       <= '0;
    end else begin
      phase_q          <= phase_d;
      tick_cnt_q       <= tick_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      mole_cnt_q       <= mole_cnt_d;
      lat_state_q      <= lat_state_d;
      keys_q           <= keys_d;
      control_signal_q <= control_signal_d;
      timer_signal_q   <= timer_signal_d;
      score_q          <= score_d;
      misses_q         <= misses_d;
      time_left_q      <= time_left_d;
      mole_led_q       <= mole_led_d;
    end
  end

  assign control_signal = control_signal_q;
  assign timer_signal   = timer_signal_q;
  assign score          = score_q;
  assign misses         = misses_q;
  assign time_left      = time_left_q;
  assign mole_led       = mole_led_q;
  assign phase_dbg      = phase_q;

endmodule

// File: tb/tb_mole_datapath.sv
// Bench for mole_datapath: directed game scenarios plus a randomized FSM emulator,
// all outputs scored every cycle against a behavioural model of the game rules.
module tb_mole_datapath;
  localparam int TICK_DIV   = 4;
  localparam int GAME_TICKS = 20;
  localparam int MOLE_TICKS = 3;
  localparam int GAP_TICKS  = 2;
  localparam int SCORE_W    = 8;
  localparam int TIME_W     = $clog2(GAME_TICKS + 1);
  localparam int MAXV       = (1 << SCORE_W) - 1;
  localparam int OW         = 2 + 2 * SCORE_W + TIME_W + 4;
  localparam int L_TIME     = 4;
  localparam int L_MISS     = L_TIME + TIME_W;
  localparam int L_SCORE    = L_MISS + SCORE_W;
  localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_ACK = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         state, keys;
  logic               control_signal, timer_signal;
  logic [SCORE_W-1:0] score, misses;
  logic [TIME_W-1:0]  time_left;
  logic [3:0]         mole_led;
  logic [1:0]         phase_dbg;

  logic [OW-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, pulses = 0;

  // behavioural model state
  int m_pc, m_ph, m_cnt, m_lat, m_score, m_misses, m_time;
  bit m_ctrl, m_timer;
  logic [3:0] m_led, m_kprev;

  mole_datapath #(
    .TICK_DIV(TICK_DIV), .GAME_TICKS(GAME_TICKS), .MOLE_TICKS(MOLE_TICKS),
    .GAP_TICKS(GAP_TICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .keys(keys),
    .control_signal(control_signal), .timer_signal(timer_signal),
    .score(score), .misses(misses), .time_left(time_left),
    .mole_led(mole_led), .phase_dbg(phase_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ph = P_IDLE; m_cnt = 0; m_lat = 0;
    m_score = 0; m_misses = 0; m_time = GAME_TICKS;
    m_ctrl = 1'b0; m_timer = 1'b0; m_led = 4'b0000; m_kprev = 4'b0000;
  endtask

  task automatic enter(input logic [3:0] s);
    m_cnt = 0;
    if (s == 1)                m_ph = P_GAP;
    else if (s >= 2 && s <= 5) m_ph = P_UP;
    else                       m_ph = P_IDLE;
  endtask

  task automatic pulse(input logic [3:0] s);
    m_ctrl = 1'b1;
    m_lat  = int'(s);
    m_ph   = P_ACK;
  endtask

  // One clock edge of the game rules, given the inputs present at that edge.
  task automatic model_step(input logic [3:0] s, input logic [3:0] k);
    bit play, mole, start, tick, old_timer;
    logic [3:0] rise, want;
    int inc;
    play      = (s >= 1) && (s <= 5);
    mole      = (s >= 2) && (s <= 5);
    start     = (s == 0) || (s > 6);
    tick      = play && ((m_pc % TICK_DIV) == TICK_DIV - 1);
    old_timer = m_timer;
    rise      = k & ~m_kprev;
    want      = mole ? (4'b0001 << (s - 4'd2)) : 4'b0000;
    m_pc      = play ? m_pc + 1 : 0;
    m_kprev   = k;
    m_ctrl    = 1'b0;
    if (start) begin
      m_time = GAME_TICKS; m_score = 0; m_misses = 0;
    end else if (tick && m_time > 0) begin
      m_time--;
    end
    m_timer = (m_time == 0) && !start;
    case (m_ph)
      P_IDLE: enter(s);
      P_GAP: begin
        if (s != 1) enter(s);
        else if (tick) begin
          if (m_cnt < GAP_TICKS) m_cnt++;
          if (m_cnt == GAP_TICKS && !old_timer) pulse(s);
        end
      end
      P_UP: begin
        if (!mole) enter(s);
        else if ((rise & want) != 0) begin
          if (m_score < MAXV) m_score++;
          pulse(s);
        end else begin
          inc = ((rise & ~want) != 0) ? 1 : 0;
          if (tick) m_cnt++;
          if (m_cnt >= MOLE_TICKS) begin
            inc++;
            pulse(s);
          end
          m_misses = (m_misses + inc > MAXV) ? MAXV : m_misses + inc;
        end
      end
      default: if (s != m_lat) enter(s);
    endcase
    m_led = (m_ph == P_UP) ? want : 4'b0000;
  endtask

  // driver: apply inputs for one cycle, then score every output
  task automatic drive_cycle(input logic [3:0] s, input logic [3:0] k);
    logic [OW-1:0] e;
    state = s;
    keys  = k;
    @(posedge clk);
    model_step(s, k);
    exp_q.push_back({m_ctrl, m_timer, SCORE_W'(m_score), SCORE_W'(m_misses), TIME_W'(m_time), m_led});
    #1;
    cyc++;
    if (control_signal) pulses++;
    e = exp_q.pop_front();
    check("control_signal", 32'(control_signal), 32'(e[OW-1]));
    check("timer_signal",   32'(timer_signal),   32'(e[OW-2]));
    check("score",          32'(score),          32'(e[L_SCORE +: SCORE_W]));
    check("misses",         32'(misses),         32'(e[L_MISS +: SCORE_W]));
    check("time_left",      32'(time_left),      32'(e[L_TIME +: TIME_W]));
    check("mole_led",       32'(mole_led),       32'(e[3:0]));
  endtask

  task automatic run(input logic [3:0] s, input logic [3:0] k, input int n,
                     output int first, output int npulse);
    int p0;
    p0    = pulses;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      drive_cycle(s, k);
      if (first < 0 && pulses != p0) first = i;
    end
    npulse = pulses - p0;
  endtask

  task automatic go_start();
    for (int i = 0; i < 3; i++) drive_cycle(4'd0, 4'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".control_signal"}, 32'(control_signal), 0);
    check({tag, ".timer_signal"},   32'(timer_signal),   0);
    check({tag, ".score"},          32'(score),          0);
    check({tag, ".misses"},         32'(misses),         0);
    check({tag, ".time_left"},      32'(time_left),      GAME_TICKS);
    check({tag, ".mole_led"},       32'(mole_led),       0);
  endtask

  logic [3:0] st, k;
  int first, np, pend, r;

  initial begin
    reset = 1'b0; state = 4'd0; keys = 4'd0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(posedge clk); #1; reset = 1'b1;

    // 1: Start -> Game, one gap request after 8 cycles, none for 40 more
    go_start();
    run(4'd1, 4'd0, 48, first, np);
    check("gap_first_pulse", 32'(first), 8);
    check("gap_pulse_count", 32'(np), 1);

    // 2: Mole4 lights, held correct key scores once
    go_start();
    drive_cycle(4'd5, 4'd0);
    check("mole4_led", 32'(mole_led), 32'h8);
    drive_cycle(4'd5, 4'd8);
    check("hit_pulse", 32'(control_signal), 1);
    check("hit_score", 32'(score), 1);
    run(4'd5, 4'd8, 3, first, np);
    run(4'd1, 4'd8, 2, first, np);
    run(4'd5, 4'd8, 5, first, np);
    check("held_key_pulses", 32'(np), 0);
    check("held_key_score", 32'(score), 1);

    // 3: Mole2 timeout, then hit on the timeout cycle
    go_start();
    run(4'd3, 4'd0, 14, first, np);
    check("timeout_first_pulse", 32'(first), 12);
    check("timeout_misses", 32'(misses), 1);
    check("timeout_score", 32'(score), 0);
    go_start();
    run(4'd3, 4'd0, 11, first, np);
    drive_cycle(4'd3, 4'd2);
    check("late_hit_pulse", 32'(control_signal), 1);
    check("late_hit_score", 32'(score), 1);
    check("late_hit_misses", 32'(misses), 0);

    // 4: wrong key on Mole3, then saturate misses
    go_start();
    drive_cycle(4'd4, 4'd0);
    drive_cycle(4'd4, 4'd1);
    check("wrong_key_misses", 32'(misses), 1);
    check("wrong_key_pulse", 32'(control_signal), 0);
    drive_cycle(4'd4, 4'd0);
    for (int b = 0; b < 90; b++) begin
      drive_cycle(4'd1, 4'd0);
      drive_cycle(4'd4, 4'd0);
      for (int j = 0; j < 3; j++) begin
        drive_cycle(4'd4, 4'd1);
        drive_cycle(4'd4, 4'd0);
      end
    end
    check("misses_sat", 32'(misses), MAXV);
    drive_cycle(4'd4, 4'd1);
    check("misses_sat_hold", 32'(misses), MAXV);

    // 5: game time runs out, gap request suppressed, GameOver then Start
    go_start();
    run(4'd1, 4'd0, 77, first, np);
    drive_cycle(4'd2, 4'd0);
    drive_cycle(4'd1, 4'd0);
    check("time_before_end", 32'(time_left), 1);
    check("timer_before_end", 32'(timer_signal), 0);
    drive_cycle(4'd1, 4'd0);
    check("time_end", 32'(time_left), 0);
    check("timer_end", 32'(timer_signal), 1);
    run(4'd1, 4'd0, 20, first, np);
    check("suppressed_pulses", 32'(np), 0);
    run(4'd6, 4'd0, 3, first, np);
    check("gameover_timer", 32'(timer_signal), 1);
    drive_cycle(4'd0, 4'd0);
    check("start_timer", 32'(timer_signal), 0);
    check("start_time", 32'(time_left), GAME_TICKS);
    check("start_score", 32'(score), 0);

    // 6: asynchronous reset mid-mole, then restart in Game
    go_start();
    run(4'd3, 4'd0, 11, first, np);
    check("pre_reset_time", 32'(time_left), 18);
    #2; reset = 1'b0; #1;
    check_reset_values("async_reset");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    state = 4'd1; reset = 1'b1;
    run(4'd1, 4'd0, 10, first, np);
    check("post_reset_first_pulse", 32'(first), 8);

    // randomized play with an FSM emulator answering requests after 3..6 cycles
    go_start();
    st = 4'd0; pend = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 9);
      if (st >= 2 && st <= 5 && r >= 6 && r < 8) k = 4'b0001 << (st - 4'd2);
      else if (r >= 8)                            k = 4'($urandom_range(0, 15));
      else                                        k = 4'd0;
      drive_cycle(st, k);
      if (m_ctrl) begin
        pend = $urandom_range(3, 6);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) st = m_timer ? 4'd6 : (st == 4'd1) ? 4'($urandom_range(2, 5)) : 4'd1;
      end else if (st == 4'd1 && m_timer) begin
        st = 4'd6;
      end else if (st == 4'd0 || st >= 4'd6) begin
        if ($urandom_range(0, 7) == 0) begin
          if (st == 4'd6) st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(7, 15)) : 4'd0;
          else            st = 4'd1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
